// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback source, commits it to the 32-entry register file,
// serves two bypassed ID-stage read ports and counts committed writes.
module wb_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] wb_alu_result,
   input  logic [DATA_W-1:0] wb_mem_data,
   input  logic [DATA_W-1:0] wb_pc,
   input  logic [ADDR_W-1:0] wb_regdst,
   input  logic [1:0]        wb_memtoreg,
   input  logic              wb_regwrite,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_commit,
   output logic [CNT_W-1:0]  write_count
);

   localparam int unsigned NREGS = 1 << ADDR_W;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_MEM  = 2'b01,
      SRC_PC   = 2'b10,
      SRC_RSVD = 2'b11
   } wb_src_e;

   logic [DATA_W-1:0] regs [NREGS];
   wb_src_e           wb_src;

   assign wb_src = wb_src_e'(wb_memtoreg);

   always_comb begin
      wb_data = wb_alu_result;
      case (wb_src)
         SRC_ALU:  wb_data = wb_alu_result;
         SRC_MEM:  wb_data = wb_mem_data;
         SRC_PC:   wb_data = wb_pc;
         SRC_RSVD: wb_data = wb_alu_result;
         default:  wb_data = wb_alu_result;
      endcase
   end

   assign wb_commit = wb_regwrite && (wb_regdst != '0);

   // Entry 0 is cleared by reset and never written, so it always holds zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_commit) begin
         regs[wb_regdst] <= wb_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         write_count <= '0;
      end else if (wb_commit) begin
         write_count <= write_count + CNT_W'(1);
      end
   end

   // Same-cycle writer wins over the array so ID sees the value being committed.
   always_comb begin
      rs_data = regs[rs_addr];
      if (rs_addr == '0) begin
         rs_data = '0;
      end else if (wb_commit && (rs_addr == wb_regdst)) begin
         rs_data = wb_data;
      end
   end

   always_comb begin
      rt_data = regs[rt_addr];
      if (rt_addr == '0) begin
         rt_data = '0;
      end else if (wb_commit && (rt_addr == wb_regdst)) begin
         rt_data = wb_data;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed checks for wb_regfile: reset, source select, r0, bypass, regwrite low,
// and counter wrap on a narrow-counter instance.
module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_alu_result, wb_mem_data, wb_pc;
   logic [4:0]  wb_regdst, rs_addr, rt_addr;
   logic [1:0]  wb_memtoreg;
   logic        wb_regwrite;
   logic [31:0] rs_data, rt_data, wb_data, write_count;
   logic        wb_commit;
   logic [31:0] rs_data4, rt_data4, wb_data4;
   logic        wb_commit4;
   logic [3:0]  write_count4;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .reset(reset),
      .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_pc(wb_pc),
      .wb_regdst(wb_regdst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
      .wb_commit(wb_commit), .write_count(write_count)
   );

   wb_regfile #(.CNT_W(4)) dut_c4 (
      .clk(clk), .reset(reset),
      .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_pc(wb_pc),
      .wb_regdst(wb_regdst), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
      .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_data(rs_data4), .rt_data(rt_data4), .wb_data(wb_data4),
      .wb_commit(wb_commit4), .write_count(write_count4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic write_reg(input logic [4:0] dst, input logic [1:0] sel, input logic [31:0] alu);
      wb_regdst     = dst;
      wb_memtoreg   = sel;
      wb_alu_result = alu;
      wb_regwrite   = 1'b1;
      step();
      wb_regwrite   = 1'b0;
   endtask

   initial begin
      logic [1:0]  sel_tab [4];
      logic [31:0] exp_tab [4];
      sel_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
      exp_tab = '{32'h11, 32'h22, 32'h0040_0008, 32'h11};

      reset = 1'b1;
      wb_alu_result = '0; wb_mem_data = '0; wb_pc = '0;
      wb_regdst = '0; wb_memtoreg = '0; wb_regwrite = 1'b0;
      rs_addr = '0; rt_addr = '0;
      step();
      check("reset_count", write_count, 32'd0);
      rs_addr = 5'd7; #1;
      check("reset_r7", rs_data, 32'd0);
      reset = 1'b0;
      step();

      // Reset clears state
      write_reg(5'd5, 2'b00, 32'hDEAD_BEEF);
      rs_addr = 5'd5; #1;
      check("pre_reset_r5", rs_data, 32'hDEAD_BEEF);
      check("pre_reset_cnt", write_count, 32'd1);
      reset = 1'b1; #1;
      check("async_reset_r5", rs_data, 32'd0);
      check("async_reset_cnt", write_count, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      check("post_reset_r5", rs_data, 32'd0);
      check("post_reset_cnt", write_count, 32'd0);

      // Source select
      wb_mem_data = 32'h22;
      wb_pc       = 32'h0040_0008;
      rs_addr     = 5'd8;
      for (int i = 0; i < 4; i++) begin
         write_reg(5'd8, sel_tab[i], 32'h11);
         #1;
         check($sformatf("src_sel%0d", i), rs_data, exp_tab[i]);
      end
      check("src_cnt", write_count, 32'd4);

      // r0 immutability
      wb_regdst = 5'd0; wb_memtoreg = 2'b00; wb_alu_result = 32'hFFFF_FFFF;
      wb_regwrite = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; #1;
      check("r0_commit", {31'd0, wb_commit}, 32'd0);
      check("r0_wbdata", wb_data, 32'hFFFF_FFFF);
      check("r0_read_now", rs_data, 32'd0);
      step();
      wb_regwrite = 1'b0; #1;
      check("r0_read_after", rt_data, 32'd0);
      check("r0_cnt", write_count, 32'd4);

      // Same-cycle bypass
      write_reg(5'd9, 2'b00, 32'h5);
      wb_regdst = 5'd9; wb_alu_result = 32'hA; wb_regwrite = 1'b1;
      rs_addr = 5'd9; rt_addr = 5'd9; #1;
      check("byp_rs", rs_data, 32'hA);
      check("byp_rt", rt_data, 32'hA);
      check("byp_commit", {31'd0, wb_commit}, 32'd1);
      step();
      wb_regwrite = 1'b0; #1;
      check("byp_held", rs_data, 32'hA);
      check("byp_cnt", write_count, 32'd6);

      // Regwrite low
      write_reg(5'd3, 2'b00, 32'h33);
      wb_regdst = 5'd3; wb_alu_result = 32'h77; wb_regwrite = 1'b0;
      rs_addr = 5'd3; rt_addr = 5'd8; #1;
      check("nowr_old", rs_data, 32'h33);
      check("nowr_commit", {31'd0, wb_commit}, 32'd0);
      check("nowr_rt_r8", rt_data, 32'h11);
      step();
      check("nowr_after", rs_data, 32'h33);
      check("nowr_cnt", write_count, 32'd7);

      // Counter wrap on the 4-bit counter instance
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      step();
      check("wrap_start", {28'd0, write_count4}, 32'd0);
      wb_regdst = 5'd1; wb_memtoreg = 2'b00; wb_regwrite = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         wb_alu_result = 32'(i);
         step();
      end
      wb_regwrite = 1'b0;
      rs_addr = 5'd1; #1;
      check("wrap_cnt4", {28'd0, write_count4}, 32'd1);
      check("wrap_cnt32", write_count, 32'd17);
      check("wrap_r1", rs_data4, 32'h11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value from the ALU result, the memory load data or the link PC, then commits it to a 32-entry general-purpose register file.
- Serves the two ID-stage read ports with write-through bypass.
- Exports the selected writeback value for EX-stage forwarding, plus a committed-write counter for debug and performance monitoring.

Parameters:
- DATA_W, 32, width of a register and of every data path.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wb_alu_result  in  DATA_W  ALU result from the MEM/WB register.
- wb_mem_data  in  DATA_W  load data from the MEM/WB register.
- wb_pc  in  DATA_W  link address from the MEM/WB register; written verbatim.
- wb_regdst  in  ADDR_W  destination register number.
- wb_memtoreg  in  2  writeback source select.
- wb_regwrite  in  1  write request.
- rs_addr  in  ADDR_W  read port A address (ID stage).
- rt_addr  in  ADDR_W  read port B address (ID stage).
- rs_data  out  DATA_W  read port A data, combinational.
- rt_data  out  DATA_W  read port B data, combinational.
- wb_data  out  DATA_W  selected writeback value, combinational, for forwarding.
- wb_commit  out  1  combinational; high when a write actually commits this cycle.
- write_count  out  CNT_W  number of committed writes since reset.

Behaviour:
- Source mux (combinational):
  - memtoreg 2'b00 -> wb_alu_result
  - 2'b01 -> wb_mem_data
  - 2'b10 -> wb_pc
  - 2'b11 (reserved) -> wb_alu_result
- Commit: wb_commit = wb_regwrite && (wb_regdst != 0).
  - On each rising clk with wb_commit=1, regs[wb_regdst] <= wb_data.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Reads, per port, evaluated combinationally in this priority:
  - addr==0 -> 0.
  - Else wb_commit && addr==wb_regdst -> wb_data (write-through bypass, so the same-cycle writer is visible).
  - Else regs[addr].
  - Both ports may address the same register, including the one being written; both return the bypassed value.
- write_count increments by 1 on each rising edge with wb_commit=1.
  - Wraps modulo 2**CNT_W with no saturation.
  - Does not count regwrite to register 0.
- Latency:
  - A value presented at cycle N appears on wb_data and on matching read ports in cycle N via bypass.
  - It is held in the array from edge N+1.
- Reset (asynchronous, takes effect immediately regardless of clk):
  - All registers, including unused entries, and write_count -> 0.
  - rs_data/rt_data therefore read 0 while reset is high, unless the bypass applies.
  - wb_data and wb_commit stay purely combinational from their inputs during reset.
  - A write coinciding with the reset deassertion edge is not required to commit; the bench does not rely on it.
- The array is not cleared by any signal other than reset. There is no stall input: upstream holds wb_regwrite=0 to bubble.
- No X propagation is allowed from unwritten entries; all entries are defined after reset.

Test Plan:
- Reset clears state: write 32'hDEADBEEF to r5, assert reset for 1 cycle, deassert -> rs_addr=5 reads 0, write_count=0.
- Source select: regdst=8, regwrite=1, alu=32'h11, mem=32'h22, pc=32'h400008.
  - memtoreg=00 -> r8=32'h11.
  - memtoreg=01 -> r8=32'h22.
  - memtoreg=10 -> r8=32'h400008.
  - memtoreg=11 -> r8=32'h11.
  - write_count=4.
- r0 immutability: regwrite=1, regdst=0, alu=32'hFFFFFFFF -> wb_commit=0, rs_addr=0 reads 0, write_count unchanged.
- Same-cycle bypass: r9 holds 32'h5; present regdst=9, alu=32'hA, regwrite=1, rs_addr=rt_addr=9 -> both read 32'hA in that cycle, before the edge; r9=32'hA afterwards.
- Regwrite low: regdst=3, alu=32'h77, regwrite=0, rs_addr=3 -> read port shows the old r3, unchanged after the edge, wb_commit=0.
- Counter wrap (CNT_W=4 build): 17 committed writes -> write_count=1.
